// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART engine.
//   - parity-mode constants PAR_NONE / PAR_EVEN / PAR_ODD
//   - TX and RX state types and their state encodings
//   - parity_bit(): parity of a data word for a given mode, used by both directions
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE   = 3'd0;
    localparam tx_state_t TX_START  = 3'd1;
    localparam tx_state_t TX_DATA   = 3'd2;
    localparam tx_state_t TX_PARITY = 3'd3;
    localparam tx_state_t TX_STOP   = 3'd4;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE      = 3'd0;
    localparam rx_state_t RX_START     = 3'd1;
    localparam rx_state_t RX_DATA      = 3'd2;
    localparam rx_state_t RX_PARITY    = 3'd3;
    localparam rx_state_t RX_STOP      = 3'd4;
    localparam rx_state_t RX_WAIT_HIGH = 3'd5;

    // Data is zero-extended to the widest legal word; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PAR_ODD) begin
            return ~p;
        end else if (mode == PAR_EVEN) begin
            return p;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_core_if.sv
// uart_core_if: word-level handshake between the board-level logic and uart_core.
//   tx_data/tx_valid -> core, tx_ready <- core (transmit request handshake)
//   rx_data/rx_valid/rx_parity_err/rx_frame_err <- core (received word and status)
// master = user of the UART, slave = uart_core.
interface uart_core_if #(
    parameter int DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

endinterface

// File: rtl/uart_rx.sv
// uart_rx: receive half of the UART engine.
// Ports:
//   clk, RSTn      - clock, asynchronous active-low reset
//   rx             - serial input, asynchronous to clk
//   rx_data        - last received word, held until the next frame completes
//   rx_valid       - one-cycle pulse when a frame completes
//   rx_parity_err  - parity mismatch of the last frame (held until next rx_valid)
//   rx_frame_err   - first stop bit of the last frame sampled low (held until next rx_valid)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    // Counter expires at 0, so a load of N-1 gives an N-cycle interval.
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic sync1_q, sync2_q, prev_q;

    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // A line back high at mid start bit was a glitch.
                    if (!sync2_q) begin
                        state_d   = RX_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {sync2_q, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = BIT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = sync2_q;
                    cnt_d   = BIT_LOAD;
                    state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    valid_d = 1'b1;
                    data_d  = shreg_q;
                    perr_d  = (PARITY != PAR_NONE) &&
                              (par_q != parity_bit(9'(shreg_q), PARITY));
                    ferr_d  = ~sync2_q;
                    // A low stop bit may be a break; wait for the line to recover.
                    state_d = sync2_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART engine with shared baud divisor.
// Ports:
//   clk, RSTn - clock, asynchronous active-low reset
//   bus       - uart_core_if slave: tx_data/tx_valid/tx_ready request handshake,
//               rx_data/rx_valid/rx_parity_err/rx_frame_err receive results
//   TX        - serial output, idle high
//   RX        - serial input, asynchronous to clk
// The transmit FSM lives here; the receive path is in uart_rx.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        RSTn,
    uart_core_if.slave  bus,
    output logic        TX,
    input  logic        RX
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 load;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        line_d     = line_q;
        load       = 1'b0;
        case (state_q)
            TX_IDLE: begin
                line_d = 1'b1;
                load   = bus.tx_valid;
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    state_d   = TX_DATA;
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = '0;
                    line_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = TX_PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d    = TX_STOP;
                            stop_idx_d = 1'b0;
                            line_d     = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        shreg_d   = shreg_q >> 1;
                        line_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TX_PARITY: begin
                if (cnt_q == '0) begin
                    state_d    = TX_STOP;
                    cnt_d      = BIT_LOAD;
                    stop_idx_d = 1'b0;
                    line_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        // A request pending at the end of the last stop bit starts
                        // the next frame on this edge, leaving no idle gap.
                        if (bus.tx_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = TX_IDLE;
                            line_d  = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        cnt_d      = BIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                line_d  = 1'b1;
            end
        endcase
        if (load) begin
            shreg_d = bus.tx_data;
            par_d   = parity_bit(9'(bus.tx_data), PARITY);
            state_d = TX_START;
            cnt_d   = BIT_LOAD;
            line_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= TX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            line_q     <= line_d;
        end
    end

    assign TX           = line_q;
    assign bus.tx_ready = (state_q == TX_IDLE);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    uart_rx #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY)
    ) u_rx (
        .clk           (clk),
        .RSTn          (RSTn),
        .rx            (RX),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err)
    );

    assign bus.rx_data       = rx_data;
    assign bus.rx_valid      = rx_valid;
    assign bus.rx_parity_err = rx_parity_err;
    assign bus.rx_frame_err  = rx_frame_err;

endmodule
